game_tick_sequencer: RTL and testbench

- Game-level controller for the score counter in the plane-dodge design.
- Generates the count-enable pulses for the 4-bit score counter from a level-dependent prescaler.
- Sequences the play state: idle, running, paused, game over.
- Raises the level, and so shortens the tick period, each time the score wraps.

---
 rtl/game_pkg.sv | 13 +
 rtl/score_counter.sv | 37 +++
 rtl/game_tick_sequencer.sv | 143 ++++++++++++++
 tb/tb_game_tick_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the plane-dodge game controller.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } game_state_e;

    localparam int unsigned SCORE_W = 4;

endpackage

// File: rtl/score_counter.sv
// Score up counter with synchronous clear and enable; wrap flags the max->0 step.
module score_counter
    import game_pkg::*;
#(
    parameter int unsigned W = SCORE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign wrap  = en & (count_q == {W{1'b1}});

endmodule

// File: rtl/game_tick_sequencer.sv
// Play-state FSM plus level-dependent prescaler that paces the score counter.
module game_tick_sequencer
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned TICK_W     = 27,
    parameter int unsigned LEVEL_STEP = 10000000,
    parameter int unsigned MAX_LEVEL  = 7,
    parameter int unsigned LVL_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               collision,
    output logic [SCORE_W-1:0] score,
    output logic [LVL_W-1:0]   level,
    output logic [1:0]         state,
    output logic               score_tick,
    output logic               running,
    output logic               game_over
);

    if (TICK_DIV <= MAX_LEVEL * LEVEL_STEP) begin : g_bad_params
        $error("TICK_DIV must exceed MAX_LEVEL*LEVEL_STEP");
    end

    localparam logic [TICK_W-1:0] TickDiv   = TICK_W'(TICK_DIV);
    localparam logic [TICK_W-1:0] LevelStep = TICK_W'(LEVEL_STEP);
    localparam logic [LVL_W-1:0]  MaxLevel  = LVL_W'(MAX_LEVEL);

    game_state_e       state_q, state_d;
    logic [TICK_W-1:0] div_cnt_q, div_cnt_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              score_tick_q, score_tick_d;

    logic [TICK_W-1:0] period;
    logic              tick;
    logic              cnt_clr;
    logic              cnt_en;
    logic              wrap;

    assign period = TickDiv - TICK_W'(level_q) * LevelStep;
    assign tick   = (state_q == ST_RUN) && (div_cnt_q == period - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                // Collision wins over pause and over a coincident tick.
                if (collision) begin
                    state_d = ST_OVER;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: if (pause) state_d = ST_RUN;
            ST_OVER:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        running   = 1'b0;
        game_over = 1'b0;
        case (state_q)
            ST_RUN:  running   = 1'b1;
            ST_OVER: game_over = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                cnt_clr   = 1'b1;
            end
            ST_RUN: begin
                if (collision || tick) begin
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
                cnt_en = tick & ~collision;
            end
            ST_OVER: begin
                div_cnt_d = '0;
                cnt_clr   = start;
            end
            default: ;
        endcase

        level_d = level_q;
        if (cnt_clr) begin
            level_d = '0;
        end else if (wrap && (level_q != MaxLevel)) begin
            level_d = level_q + 1'b1;
        end

        score_tick_d = cnt_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            level_q      <= '0;
            score_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            level_q      <= level_d;
            score_tick_q <= score_tick_d;
        end
    end

    score_counter #(
        .W(SCORE_W)
    ) u_score_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (score),
        .wrap  (wrap)
    );

    assign level      = level_q;
    assign state      = state_q;
    assign score_tick = score_tick_q;

endmodule

// File: tb/tb_game_tick_sequencer.sv
// Directed bench for game_tick_sequencer with a 10-cycle base tick and 4 levels.
module tb_game_tick_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       collision = 1'b0;
    logic [3:0] score;
    logic [1:0] level;
    logic [1:0] state;
    logic       score_tick;
    logic       running;
    logic       game_over;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    game_tick_sequencer #(
        .TICK_DIV   (10),
        .TICK_W     (4),
        .LEVEL_STEP (1),
        .MAX_LEVEL  (3),
        .LVL_W      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .collision  (collision),
        .score      (score),
        .level      (level),
        .state      (state),
        .score_tick (score_tick),
        .running    (running),
        .game_over  (game_over)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
        checks++; if (score !== 4'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (score_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", score_tick); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over: got %b want 0", game_over); end
        start = 1'b1;
        collision = 1'b1;
        step(1);
        start = 1'b0;
        collision = 1'b0;
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL idle_start_state: got %b want 01", state); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL idle_start_running: got %b want 1", running); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL idle_collision_ignored: got %b want 0", game_over); end
    endtask

    task automatic test_tick_and_wrap();
        int pulses = 0;
        do_reset();
        start_game();
        for (int n = 1; n <= 169; n++) begin
            step(1);
            if (n <= 11 && score_tick === 1'b1) pulses++;
            if (n == 9) begin
                checks++; if (score !== 4'd0) begin errors++; $display("FAIL pre_first_tick: got %0d want 0", score); end
            end
            if (n == 10) begin
                checks++; if (score !== 4'd1) begin errors++; $display("FAIL first_tick_score: got %0d want 1", score); end
                checks++; if (score_tick !== 1'b1) begin errors++; $display("FAIL first_tick_pulse: got %b want 1", score_tick); end
            end
            if (n == 11) begin
                checks++; if (pulses != 1) begin errors++; $display("FAIL tick_pulse_count: got %0d want 1", pulses); end
                checks++; if (score_tick !== 1'b0) begin errors++; $display("FAIL tick_pulse_width: got %b want 0", score_tick); end
            end
            if (n == 159) begin
                checks++; if (score !== 4'd15) begin errors++; $display("FAIL pre_wrap_score: got %0d want 15", score); end
                checks++; if (level !== 2'd0) begin errors++; $display("FAIL pre_wrap_level: got %0d want 0", level); end
            end
            if (n == 160) begin
                checks++; if (score !== 4'd0) begin errors++; $display("FAIL wrap_score: got %0d want 0", score); end
                checks++; if (level !== 2'd1) begin errors++; $display("FAIL wrap_level: got %0d want 1", level); end
            end
            if (n == 168) begin
                checks++; if (score !== 4'd0) begin errors++; $display("FAIL lvl1_early: got %0d want 0", score); end
            end
            if (n == 169) begin
                checks++; if (score !== 4'd1) begin errors++; $display("FAIL lvl1_period9: got %0d want 1", score); end
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        start_game();
        step(3);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL pause_enter: got %b want 10", state); end
        for (int n = 0; n < 20; n++) begin
            step(1);
            checks++; if (score !== 4'd0 || state !== 2'b10) begin
                errors++; $display("FAIL pause_hold: got score=%0d state=%b want score=0 state=10", score, state);
            end
        end
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL pause_resume: got %b want 01", state); end
        step(5);
        checks++; if (score !== 4'd0) begin errors++; $display("FAIL resume_early: got %0d want 0", score); end
        step(1);
        checks++; if (score !== 4'd1) begin errors++; $display("FAIL resume_tick: got %0d want 1", score); end
        checks++; if (score_tick !== 1'b1) begin errors++; $display("FAIL resume_pulse: got %b want 1", score_tick); end
    endtask

    task automatic test_collision();
        int pulses = 0;
        do_reset();
        start_game();
        step(59);
        checks++; if (score !== 4'd5) begin errors++; $display("FAIL coll_pre_score: got %0d want 5", score); end
        collision = 1'b1;
        step(1);
        collision = 1'b0;
        checks++; if (score !== 4'd5) begin errors++; $display("FAIL coll_score_held: got %0d want 5", score); end
        checks++; if (score_tick !== 1'b0) begin errors++; $display("FAIL coll_no_pulse: got %b want 0", score_tick); end
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL coll_state: got %b want 11", state); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL coll_game_over: got %b want 1", game_over); end
        for (int n = 0; n < 100; n++) begin
            step(1);
            if (score_tick === 1'b1) pulses++;
        end
        checks++; if (score !== 4'd5 || pulses != 0) begin
            errors++; $display("FAIL over_frozen: got score=%0d pulses=%0d want score=5 pulses=0", score, pulses);
        end
        start_game();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL restart_state: got %b want 01", state); end
        checks++; if (score !== 4'd0 || level !== 2'd0) begin
            errors++; $display("FAIL restart_clear: got score=%0d level=%0d want 0 0", score, level);
        end
        step(9);
        checks++; if (score !== 4'd0) begin errors++; $display("FAIL restart_early: got %0d want 0", score); end
        step(1);
        checks++; if (score !== 4'd1) begin errors++; $display("FAIL restart_first_tick: got %0d want 1", score); end
        // Collision beats a coincident pause.
        step(2);
        pause = 1'b1;
        collision = 1'b1;
        step(1);
        pause = 1'b0;
        collision = 1'b0;
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL coll_over_pause: got %b want 11", state); end
    endtask

    task automatic test_level_saturation();
        do_reset();
        start_game();
        for (int n = 1; n <= 663; n++) begin
            step(1);
            if (n == 304) begin
                checks++; if (level !== 2'd2) begin errors++; $display("FAIL wrap2_level: got %0d want 2", level); end
            end
            if (n == 432) begin
                checks++; if (level !== 2'd3) begin errors++; $display("FAIL wrap3_level: got %0d want 3", level); end
            end
            if (n == 544) begin
                checks++; if (level !== 2'd3 || score !== 4'd0) begin
                    errors++; $display("FAIL wrap4_sat: got level=%0d score=%0d want 3 0", level, score);
                end
            end
            if (n == 656) begin
                checks++; if (level !== 2'd3 || score !== 4'd0) begin
                    errors++; $display("FAIL wrap5_sat: got level=%0d score=%0d want 3 0", level, score);
                end
            end
            if (n == 662) begin
                checks++; if (score !== 4'd0) begin errors++; $display("FAIL lvl3_early: got %0d want 0", score); end
            end
            if (n == 663) begin
                checks++; if (score !== 4'd1) begin errors++; $display("FAIL lvl3_period7: got %0d want 1", score); end
            end
        end
    endtask

    task automatic test_reset_mid_pause();
        do_reset();
        start_game();
        step(376);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++; if (state !== 2'b10 || score !== 4'd9 || level !== 2'd2) begin
            errors++; $display("FAIL pre_reset_pause: got state=%b score=%0d level=%0d want 10 9 2", state, score, level);
        end
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL midpause_reset_state: got %b want 00", state); end
        checks++; if (score !== 4'd0 || level !== 2'd0) begin
            errors++; $display("FAIL midpause_reset_clear: got score=%0d level=%0d want 0 0", score, level);
        end
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_pause_ignored: got %b want 00", state); end
        collision = 1'b1;
        step(1);
        collision = 1'b0;
        step(12);
        checks++; if (state !== 2'b00 || score !== 4'd0) begin
            errors++; $display("FAIL idle_static: got state=%b score=%0d want 00 0", state, score);
        end
    endtask

    initial begin
        test_reset();
        test_tick_and_wrap();
        test_pause();
        test_collision();
        test_level_saturation();
        test_reset_mid_pause();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
